mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameters: none; datapath fixed at 32 bits; the register-file source ports and the HI/LO result path are 32 bits.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  launches operation selected by op on operands a, b.
REQ-005 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  input  32  rs operand from register file read port 1.
REQ-007 b  input  32  rt operand from register file read port 2.
REQ-008 hi_wen  input  1  MTHI write strobe.
REQ-009 lo_wen  input  1  MTLO write strobe.
REQ-010 wdata  input  32  MTHI/MTLO data.
REQ-011 busy  output  1  operation in progress.
REQ-012 done  output  1  one-cycle completion pulse, registered.
REQ-013 hi  output  32  HI register, consumed by MFHI writeback into the register file.
REQ-014 lo  output  32  LO register, consumed by MFLO writeback into the register file.

Function
REQ-015 FSM states IDLE, ITER, FIN; busy SHALL be 1 exactly when state != IDLE.
REQ-016 start SHALL be accepted only in IDLE; start in ITER/FIN SHALL be ignored with no side effect.
REQ-017 On the accepting edge E0, the unit SHALL latch a, b and op, clear the iteration counter, and enter ITER.
REQ-018 ITER SHALL perform one iteration per edge on E1..E32 (counter 0..31); at E32 the FSM SHALL enter FIN.
REQ-019 At E33 the FSM SHALL write HI/LO, set done=1 for exactly one cycle, and return to IDLE; busy SHALL be 0 in the same cycle that done=1.
REQ-020 Multiply SHALL be shift-add over operand magnitudes, with the 64-bit product negated when MULT operand signs differ; {hi,lo} SHALL equal the exact 64-bit product.
REQ-021 Divide SHALL be restoring over magnitudes; lo=quotient truncated toward zero; hi=remainder carrying the dividend's sign (DIV) or unsigned (DIVU).
REQ-022 Divide by zero (b=0, DIV or DIVU) SHALL complete at normal latency with lo=32'hFFFF_FFFF and hi=a.
REQ-023 DIV with a=32'h8000_0000 and b=32'hFFFF_FFFF SHALL give lo=32'h8000_0000, hi=0.
REQ-024 hi_wen/lo_wen SHALL update hi/lo at the edge when busy=0; they SHALL be ignored while busy=1.
REQ-025 hi_wen/lo_wen coincident with an accepted start SHALL take effect, and the operation SHALL overwrite both at its E33.
REQ-026 hi/lo SHALL hold their values during ITER/FIN; intermediate results SHALL NOT be visible.
REQ-027 Back-to-back: start asserted in the done cycle SHALL be accepted (FSM is in IDLE).
REQ-028 Operand inputs changing after E0 SHALL NOT affect the result.

Reset
REQ-029 rst SHALL force IDLE, busy=0, done=0, hi=0, lo=0, counter=0; it SHALL override start and hi_wen/lo_wen.
REQ-030 rst during ITER/FIN SHALL abort the operation with no done pulse; the first edge with rst=0 SHALL accept a new start.

Verification
REQ-031 MULTU a=FFFFFFFF b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; done on the 34th cycle after start; busy high for 33 cycles.
REQ-032 MULT a=FFFFFFFD(-3) b=5 -> hi=FFFFFFFF, lo=FFFFFFF1; DIV a=FFFFFFF9(-7) b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-033 DIVU a=100 b=0 -> lo=FFFFFFFF, hi=100; DIV a=80000000 b=FFFFFFFF -> lo=80000000, hi=0.
REQ-034 Second start pulsed 5 cycles into a MULTU 3*4 with a=9 b=9 -> result hi=0, lo=12; exactly one done pulse.
REQ-035 rst asserted 10 cycles into DIVU 50/7 -> busy=0, hi=lo=0, no done; DIVU 50/7 restarted -> lo=7, hi=1.
REQ-036 lo_wen with wdata=DEADBEEF while idle -> lo=DEADBEEF next cycle; same lo_wen while busy -> lo unchanged.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit -- iterative 32-bit multiply/divide unit with HI/LO registers.
//
// Ports:
//   clk     : clock, all state updates on rising edge
//   rst     : synchronous active-high reset
//   start   : launch the operation selected by op (accepted only when idle)
//   op      : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b    : rs / rt operands, latched on the accepting edge
//   hi_wen  : MTHI write strobe (honoured only when not busy)
//   lo_wen  : MTLO write strobe (honoured only when not busy)
//   wdata   : MTHI/MTLO write data
//   busy    : operation in progress (state != IDLE)
//   done    : one-cycle registered completion pulse
//   hi, lo  : HI/LO architectural registers
//
// Timing: accepting edge E0 -> 32 iteration edges E1..E32 -> E33 writes
// HI/LO and raises done while returning to IDLE.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_wen,
  input  logic        lo_wen,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic        is_div;
  logic        neg_res;
  logic        neg_rem;
  logic        b_zero;
  logic [31:0] a_q;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [31:0] mag_op;
  // Multiply: {partial product high, multiplier/low product}.
  // Divide:   {partial remainder, dividend/quotient}.
  logic [63:0] acc;

  // Operand magnitude extraction on the inputs (used only at accept).
  logic        signed_op;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & a[31];
    b_neg     = signed_op & b[31];
    a_mag     = a_neg ? (~a + 32'd1) : a;
    b_mag     = b_neg ? (~b + 32'd1) : b;
  end

  // One iteration of shift-add multiply or restoring divide.
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [31:0] div_diff;
  logic        div_ge;
  logic [63:0] acc_next;

  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_op} : 33'd0);
    div_shift = acc[63:31];
    div_ge    = (div_shift >= {1'b0, mag_op});
    // When div_ge holds the true difference is below mag_op, so 32 bits suffice.
    div_diff  = div_shift[31:0] - mag_op;
    if (is_div) begin
      acc_next = div_ge ? {div_diff, acc[30:0], 1'b1}
                        : {div_shift[31:0], acc[30:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc[31:1]};
    end
  end

  // Sign correction of the final magnitudes.
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;

  always_comb begin
    prod = neg_res ? (~acc + 64'd1) : acc;
    quo  = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem  = neg_rem ? (~acc[63:32] + 32'd1) : acc[63:32];
  end

  assign busy = (state != IDLE);

  // Control and datapath state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      a_q     <= '0;
      mag_op  <= '0;
      acc     <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == FIN);
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ITER;
            cnt     <= '0;
            is_div  <= op[1];
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            b_zero  <= (b == 32'd0);
            a_q     <= a;
            mag_op  <= op[1] ? b_mag : a_mag;
            acc     <= op[1] ? {32'd0, a_mag} : {32'd0, b_mag};
          end
        end
        ITER: begin
          acc <= acc_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // HI/LO: software writes only while idle (including the accepting edge);
  // the operation result replaces both at the FIN edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIN) begin
      if (!is_div) begin
        hi <= prod[63:32];
        lo <= prod[31:0];
      end else if (b_zero) begin
        hi <= a_q;
        lo <= '1;
      end else begin
        hi <= rem;
        lo <= quo;
      end
    end else if (state == IDLE) begin
      if (hi_wen) hi <= wdata;
      if (lo_wen) lo <= wdata;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_wen;
  logic        lo_wen;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  logic [63:0] sb[$];

  mul_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_wen(hi_wen), .lo_wen(lo_wen), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on 64-bit values.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy, res;
    ux = {32'd0, x};
    uy = {32'd0, y};
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      2'b00: res = sx * sy;
      2'b01: res = ux * uy;
      2'b10: begin
        if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
        else res = {32'(ux % uy), 32'(ux / uy)};
      end
    endcase
    return res;
  endfunction

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      check("busy_at_done", {63'd0, busy}, 64'd0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
      end else begin
        check("result", {hi, lo}, sb.pop_front());
      end
    end
  end

  // Drive a start for one cycle; caller is away from the rising edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit push, input logic [63:0] exp);
    op = o; a = x; b = y; start = 1'b1;
    if (push) sb.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && !done; i++) @(negedge clk);
    if (!done) @(negedge clk);
    check("done_timeout", {63'd0, done}, 64'd1);
  endtask

  task automatic mtlo(input logic [31:0] d);
    lo_wen = 1'b1; wdata = d;
    @(posedge clk);
    #1;
    lo_wen = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, busy_c, dc0;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    hi_wen = 1'b0; lo_wen = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    rst = 1'b0;

    // MULTU max*max with latency measurement.
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFE_0000_0001);
    lat = 0; busy_c = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (busy) busy_c++;
      if (done) break;
    end
    check("latency", 64'(lat), 64'd34);
    check("busy_cycles", 64'(busy_c), 64'd33);

    // Directed signed / special cases, back-to-back from the done cycle.
    issue(2'b00, 32'hFFFF_FFFD, 32'd5, 1, 64'hFFFF_FFFF_FFFF_FFF1);
    wait_done();
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1, 64'hFFFF_FFFF_FFFF_FFFD);
    wait_done();
    issue(2'b11, 32'd100, 32'd0, 1, 64'h0000_0064_FFFF_FFFF);
    wait_done();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 64'h0000_0000_8000_0000);
    wait_done();
    issue(2'b10, 32'h1234_5678, 32'd0, 1, 64'h1234_5678_FFFF_FFFF);
    wait_done();

    // Second start mid-operation is ignored.
    @(negedge clk);
    dc0 = done_cnt;
    issue(2'b01, 32'd3, 32'd4, 1, 64'd12);
    repeat (5) @(negedge clk);
    issue(2'b01, 32'd9, 32'd9, 0, 64'd0);
    wait_done();
    repeat (40) @(negedge clk);
    check("single_done", 64'(done_cnt - dc0), 64'd1);

    // Reset aborts mid-operation.
    issue(2'b11, 32'd50, 32'd7, 1, 64'h0000_0001_0000_0007);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    void'(sb.pop_back());
    @(posedge clk);
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    issue(2'b11, 32'd50, 32'd7, 1, 64'h0000_0001_0000_0007);
    wait_done();

    // MTLO idle vs busy; MTHI coincident with start.
    @(negedge clk);
    mtlo(32'hDEAD_BEEF);
    check("mtlo_idle", {32'd0, lo}, 64'h0000_0000_DEAD_BEEF);
    hi_wen = 1'b1; wdata = 32'hCAFE_F00D;
    issue(2'b01, 32'd6, 32'd7, 1, 64'd42);
    hi_wen = 1'b0;
    check("mthi_with_start", {32'd0, hi}, 64'h0000_0000_CAFE_F00D);
    repeat (3) @(negedge clk);
    mtlo(32'h1234_5678);
    check("mtlo_busy", {32'd0, lo}, 64'h0000_0000_DEAD_BEEF);
    hi_wen = 1'b1; wdata = 32'h5555_5555;
    @(posedge clk);
    #1;
    hi_wen = 1'b0;
    check("mthi_busy", {32'd0, hi}, 64'h0000_0000_CAFE_F00D);
    wait_done();

    // Randomized operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      issue(ro, ra, rb, 1, ref_model(ro, ra, rb));
      wait_done();
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
